// File: rtl/jtlt_pkg.sv
// Shared types, default timing constants and width helpers for the
// multi-channel clock-sampled JTL timing model.
package jtlt_pkg;

  typedef enum logic {
    OUT_TOGGLE = 1'b0,
    OUT_PULSE  = 1'b1
  } out_mode_e;

  localparam int DEF_DELAY_CYC   = 45;
  localparam int DEF_CT_CYC      = 201;
  localparam int DEF_STARTUP_CYC = 40;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/jtlt_chan.sv
// One JTL channel: edge detect, critical-timing window, fixed-depth pulse
// delay line, sticky error/unknown flag and toggle-or-pulse output.
module jtlt_chan
  import jtlt_pkg::*;
#(
  parameter int        DELAY_CYC = DEF_DELAY_CYC,
  parameter int        CT_CYC    = DEF_CT_CYC,
  parameter out_mode_e OUT_MODE  = OUT_TOGGLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_i,
  input  logic ready_i,
  input  logic clr_err_i,
  output logic q_o,
  output logic err_o,
  output logic viol_o
);

  localparam int            WW       = cnt_width(CT_CYC - 1);
  localparam logic [WW-1:0] WIN_LOAD = WW'(CT_CYC - 1);

  logic                 a_q;
  logic [WW-1:0]        win_q, win_d;
  logic [DELAY_CYC-1:0] dl_q, dl_d;
  logic                 err_q, err_d;
  logic                 tog_q, tog_d;
  logic                 edge_s, acc_s, ev_s;

  always_comb begin
    edge_s = a_i ^ a_q;
    viol_o = ready_i & edge_s & (win_q != '0);
    acc_s  = ready_i & edge_s & (win_q == '0) & ~err_q;
    // An errored channel drops whatever is still travelling down its line.
    ev_s   = dl_q[DELAY_CYC-1] & ~err_q;

    win_d = win_q;
    if (acc_s)             win_d = WIN_LOAD;
    else if (win_q != '0)  win_d = win_q - WW'(1);

    dl_d = '0;
    if (!err_q) begin
      dl_d[0] = acc_s;
      for (int i = 1; i < DELAY_CYC; i++) dl_d[i] = dl_q[i-1];
    end

    err_d = err_q;
    if (viol_o)         err_d = 1'b1;
    else if (clr_err_i) err_d = 1'b0;

    tog_d = tog_q ^ ev_s;
  end

  // Output reflects the event in the cycle it is due, not one cycle later.
  assign q_o   = (OUT_MODE == OUT_PULSE) ? ev_s : tog_d;
  assign err_o = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= 1'b0;
      win_q <= '0;
      dl_q  <= '0;
      err_q <= 1'b0;
      tog_q <= 1'b0;
    end else begin
      a_q   <= a_i;
      win_q <= win_d;
      dl_q  <= dl_d;
      err_q <= err_d;
      tog_q <= tog_d;
    end
  end

endmodule

// File: rtl/jtlt_multi_timed.sv
// Multi-channel JTL timing cell: shared startup gate, per-channel timing
// channels, saturating violation counter and error summary.
module jtlt_multi_timed
  import jtlt_pkg::*;
#(
  parameter int        CHANNELS    = 4,
  parameter int        DELAY_CYC   = DEF_DELAY_CYC,
  parameter int        CT_CYC      = DEF_CT_CYC,
  parameter int        STARTUP_CYC = DEF_STARTUP_CYC,
  parameter out_mode_e OUT_MODE    = OUT_TOGGLE,
  parameter int        CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] a,
  input  logic                clr_err,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_x,
  output logic                err_any,
  output logic [CNT_W-1:0]    viol_cnt,
  output logic                ready
);

  localparam int              SW     = cnt_width(STARTUP_CYC);
  localparam logic [SW-1:0]   SU_END = SW'(STARTUP_CYC);
  localparam int              PW     = cnt_width(CHANNELS);
  localparam int              SUMW   = CNT_W + PW;
  localparam logic [SUMW-1:0] MAXV   = {{PW{1'b0}}, {CNT_W{1'b1}}};

  logic [SW-1:0]       su_q, su_d;
  logic [CHANNELS-1:0] err, viol;
  logic [PW-1:0]       pop;
  logic [SUMW-1:0]     base, sum;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  assign ready = (su_q == SU_END);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    jtlt_chan #(
      .DELAY_CYC (DELAY_CYC),
      .CT_CYC    (CT_CYC),
      .OUT_MODE  (OUT_MODE)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_i       (a[g]),
      .ready_i   (ready),
      .clr_err_i (clr_err),
      .q_o       (q[g]),
      .err_o     (err[g]),
      .viol_o    (viol[g])
    );
  end

  always_comb begin
    su_d = ready ? su_q : su_q + SW'(1);

    pop = '0;
    for (int i = 0; i < CHANNELS; i++) pop = pop + PW'(viol[i]);

    // A clear restarts the count from this cycle's violations.
    base  = clr_err ? '0 : SUMW'(cnt_q);
    sum   = base + SUMW'(pop);
    cnt_d = (sum > MAXV) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  assign q_x      = err;
  assign err_any  = |err;
  assign viol_cnt = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      su_q  <= '0;
      cnt_q <= '0;
    end else begin
      su_q  <= su_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_jtlt_multi_timed.sv
// Bench for jtlt_multi_timed: directed timing scenarios plus random pulse
// trains, checked every cycle against an event-list reference model.
module tb_jtlt_multi_timed;
  import jtlt_pkg::*;

  localparam int NCH  = 2;
  localparam int D    = 3;
  localparam int CT   = 5;
  localparam int SU   = 4;
  localparam int CW   = 3;
  localparam int VMAX = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] a = '0;
  logic           clr_err = 1'b0;

  logic [NCH-1:0] q_t, qx_t, q_p, qx_p;
  logic           ea_t, ea_p, rdy_t, rdy_p;
  logic [CW-1:0]  cnt_t, cnt_p;

  jtlt_multi_timed #(
    .CHANNELS(NCH), .DELAY_CYC(D), .CT_CYC(CT), .STARTUP_CYC(SU),
    .OUT_MODE(OUT_TOGGLE), .CNT_W(CW)
  ) u_tog (
    .clk(clk), .rst_n(rst_n), .a(a), .clr_err(clr_err),
    .q(q_t), .q_x(qx_t), .err_any(ea_t), .viol_cnt(cnt_t), .ready(rdy_t)
  );

  jtlt_multi_timed #(
    .CHANNELS(NCH), .DELAY_CYC(D), .CT_CYC(CT), .STARTUP_CYC(SU),
    .OUT_MODE(OUT_PULSE), .CNT_W(CW)
  ) u_pul (
    .clk(clk), .rst_n(rst_n), .a(a), .clr_err(clr_err),
    .q(q_p), .q_x(qx_p), .err_any(ea_p), .viol_cnt(cnt_p), .ready(rdy_p)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int             cyc;
  int             scen;
  logic [NCH-1:0] in_a, a_prev;
  logic           in_clr;
  int             last_acc [NCH];
  bit             has_acc [NCH];
  bit             err_m [NCH];
  bit             tog [NCH];
  int             pend [NCH][$];
  int             vcnt;
  logic [NCH-1:0] exp_q, exp_p, exp_x;
  logic           exp_ready;

  function automatic int sat(input int v);
    return (v > VMAX) ? VMAX : v;
  endfunction

  task automatic model_clear();
    cyc = 0; a_prev = '0; vcnt = 0;
    exp_q = '0; exp_p = '0; exp_x = '0; exp_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      has_acc[i] = 0; err_m[i] = 0; tog[i] = 0; last_acc[i] = 0;
      pend[i].delete();
    end
  endtask

  // Consume the inputs of cycle cyc, then form expectations for cyc+1.
  task automatic model_step();
    int  pop;
    bit  rdy, e, inwin;
    pop = 0;
    rdy = (cyc >= SU);
    for (int i = 0; i < NCH; i++) begin
      e     = (in_a[i] != a_prev[i]);
      inwin = has_acc[i] && (cyc - last_acc[i] < CT);
      if (rdy && e && inwin) begin
        pop++;
        err_m[i] = 1;
      end else begin
        if (rdy && e && !err_m[i]) begin
          pend[i].push_back(cyc + D);
          last_acc[i] = cyc;
          has_acc[i]  = 1;
        end
        if (in_clr) err_m[i] = 0;
      end
    end
    vcnt   = in_clr ? sat(pop) : sat(vcnt + pop);
    a_prev = in_a;
    cyc++;
    for (int i = 0; i < NCH; i++) begin
      bit evt;
      evt = 0;
      if (err_m[i]) pend[i].delete();
      else if (pend[i].size() > 0 && pend[i][0] == cyc) begin
        evt = 1;
        void'(pend[i].pop_front());
      end
      tog[i]   = tog[i] ^ evt;
      exp_q[i] = tog[i];
      exp_p[i] = evt;
      exp_x[i] = err_m[i];
    end
    exp_ready = (cyc >= SU);
  endtask

  // ---------------- compare process ----------------
  int checks = 0;
  int failures = 0;

  localparam int S_QT = 0, S_QP = 1, S_QX = 2, S_CNT = 3, S_RDY = 4, S_ERR = 5;
  typedef struct { int sc; int cy; int sel; int val; } lit_t;
  localparam int NLIT = 37;
  lit_t lits [NLIT] = '{
    '{1, 3, S_RDY, 0}, '{1, 4, S_RDY, 1}, '{1, 4, S_QT, 0}, '{1, 5, S_QT, 0},
    '{1, 5, S_QX, 0},  '{1, 12, S_QT, 0}, '{1, 13, S_QT, 1}, '{1, 12, S_QP, 0},
    '{1, 13, S_QP, 1}, '{1, 14, S_QP, 0}, '{1, 17, S_QT, 1}, '{1, 18, S_QT, 0},
    '{1, 18, S_CNT, 0}, '{1, 23, S_QT, 1}, '{1, 25, S_QX, 1}, '{1, 25, S_ERR, 1},
    '{1, 25, S_CNT, 1}, '{1, 27, S_QT, 1},
    '{2, 27, S_QT, 1}, '{2, 28, S_QT, 0}, '{2, 28, S_QX, 0}, '{2, 32, S_CNT, 2},
    '{2, 33, S_CNT, 4}, '{2, 34, S_CNT, 6}, '{2, 35, S_CNT, 7}, '{2, 35, S_QX, 3},
    '{2, 35, S_ERR, 1}, '{2, 36, S_CNT, 7}, '{2, 41, S_CNT, 0}, '{2, 41, S_QX, 0},
    '{2, 44, S_QX, 1}, '{2, 44, S_CNT, 1}, '{2, 45, S_QX, 2}, '{2, 45, S_CNT, 1},
    '{2, 47, S_QX, 0},
    '{3, 0, S_QT, 0},  '{3, 4, S_QT, 0}
  };

  function automatic int sig(input int sel);
    case (sel)
      S_QT:    return int'(q_t);
      S_QP:    return int'(q_p);
      S_QX:    return int'(qx_t);
      S_CNT:   return int'(cnt_t);
      S_RDY:   return int'(rdy_t);
      default: return int'(ea_t);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s scen=%0d cycle=%0d: got %0d expected %0d",
               name, scen, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("q_tog",     int'(q_t),   int'(exp_q));
    chk("q_pulse",   int'(q_p),   int'(exp_p));
    chk("q_x_tog",   int'(qx_t),  int'(exp_x));
    chk("q_x_pulse", int'(qx_p),  int'(exp_x));
    chk("err_any_t", int'(ea_t),  int'(|exp_x));
    chk("err_any_p", int'(ea_p),  int'(|exp_x));
    chk("viol_cnt_t", int'(cnt_t), vcnt);
    chk("viol_cnt_p", int'(cnt_p), vcnt);
    chk("ready_t",   int'(rdy_t), int'(exp_ready));
    chk("ready_p",   int'(rdy_p), int'(exp_ready));
    for (int k = 0; k < NLIT; k++)
      if (lits[k].sc == scen && lits[k].cy == cyc)
        chk($sformatf("lit%0d", k), sig(lits[k].sel), lits[k].val);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [NCH-1:0] av, input logic cv);
    a = av; clr_err = cv;
    in_a = av; in_clr = cv;
    @(posedge clk); #1;
    model_step();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick(a, 1'b0);
  endtask

  task automatic ev(input int c, input logic [NCH-1:0] m, input logic cv);
    run_to(c);
    tick(a ^ m, cv);
  endtask

  task automatic do_reset(input int next_scen);
    scen = 0;
    rst_n = 1'b0;
    a = '0; clr_err = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    scen = next_scen;
  endtask

  initial begin
    model_clear();
    scen = 0;

    // Startup gating, delay and window boundary (violation side).
    do_reset(1);
    ev(2, 2'b01, 1'b0);
    ev(10, 2'b01, 1'b0);
    ev(15, 2'b01, 1'b0);
    ev(20, 2'b01, 1'b0);
    ev(24, 2'b01, 1'b0);
    run_to(28);

    // Window boundary (accept side), saturation, clear vs. violation.
    do_reset(2);
    ev(20, 2'b01, 1'b0);
    ev(25, 2'b01, 1'b0);
    ev(30, 2'b11, 1'b0);
    for (int c = 31; c <= 34; c++) ev(c, 2'b11, 1'b0);
    ev(40, 2'b00, 1'b1);
    ev(42, 2'b11, 1'b0);
    ev(43, 2'b01, 1'b0);
    ev(44, 2'b10, 1'b1);
    ev(46, 2'b00, 1'b1);
    ev(50, 2'b01, 1'b0);

    // Reset while a toggle is still in flight.
    do_reset(3);
    run_to(10);

    // Random pulse trains: dense first, then sparse, with one reset between.
    do_reset(4);
    for (int n = 0; n < 3000; n++) begin
      logic [NCH-1:0] m;
      int dens;
      if (n == 1500) do_reset(4);
      dens = (n < 1500) ? 5 : 11;
      for (int i = 0; i < NCH; i++) m[i] = ($urandom_range(0, dens) == 0);
      tick(a ^ m, $urandom_range(0, 30) == 0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
